// File: rtl/round_key_store.sv
// Round-key store: two 16x64 banks fed by key expansion, streamed out as 128-bit round keys.
// Define ROUND_KEY_STORE_DEC_EN to honour rk_dec (reverse-order sequences for decryption).
module round_key_store (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   key_mode,
    input  logic         key_start,
    input  logic         key_ready,
    input  logic         wr,
    input  logic [4:0]   wr_addr,
    input  logic [63:0]  wr_data,
    input  logic         rk_start,
    input  logic         rk_dec,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         busy,
    output logic         key_loaded,
    output logic         rk_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    logic [63:0]  bank0_q [16];
    logic [63:0]  bank1_q [16];

    state_e       state_q;
    logic [3:0]   nr_q;
    logic [3:0]   idx_q;
    logic         rd_pend_q;
    logic [3:0]   rd_addr_q;
    logic         rd_last_q;
    logic         rk_err_q;

    logic [127:0] fifo_data_q [2];
    logic [3:0]   fifo_round_q [2];
    logic         fifo_last_q [2];
    logic [1:0]   cnt_q;
    logic         wptr_q;
    logic         rptr_q;

    logic         kr_s_q;
    logic         kr_q;
    logic         key_loaded_q;

    logic [3:0]   nr_sel;
    logic         dec_sel;
    logic [3:0]   idx_next;
    logic         idx_last;
    logic         pop;
    logic         issue;
    logic         drain_done;
    logic         abort;
    logic [2:0]   occ;

`ifdef ROUND_KEY_STORE_DEC_EN
    logic         dec_q;

    assign dec_sel  = rk_dec;
    assign idx_next = dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
    assign idx_last = dec_q ? (idx_q == 4'd0) : (idx_q == nr_q);
`else
    logic         unused_rk_dec;

    assign unused_rk_dec = rk_dec;
    assign dec_sel       = 1'b0;
    assign idx_next      = idx_q + 4'd1;
    assign idx_last      = (idx_q == nr_q);
`endif

    always_comb begin
        nr_sel = 4'd14;
        case (key_mode)
            2'd0:    nr_sel = 4'd10;
            2'd1:    nr_sel = 4'd12;
            default: nr_sel = 4'd14;
        endcase
    end

    assign pop   = rk_valid && rk_ready;
    assign abort = key_start && (state_q != StIdle);
    // Slots counted after this cycle's pop, so a full-rate stream never starves for credit.
    assign occ        = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue      = (state_q == StRun) && (occ < 3'd2);
    assign drain_done = !rd_pend_q && (cnt_q == {1'b0, pop});

    always_ff @(posedge clk) begin
        if (wr) begin
            if (wr_addr[0]) begin
                bank1_q[wr_addr[4:1]] <= wr_data;
            end else begin
                bank0_q[wr_addr[4:1]] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            nr_q      <= 4'd0;
            idx_q     <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= 4'd0;
            rd_last_q <= 1'b0;
            rk_err_q  <= 1'b0;
`ifdef ROUND_KEY_STORE_DEC_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            rk_err_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rk_start) begin
                        if (!key_loaded_q) begin
                            rk_err_q <= 1'b1;
                        end else if (!key_start) begin
                            state_q <= StRun;
                            nr_q    <= nr_sel;
                            idx_q   <= dec_sel ? nr_sel : 4'd0;
`ifdef ROUND_KEY_STORE_DEC_EN
                            dec_q   <= dec_sel;
`endif
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        rd_pend_q <= 1'b1;
                        rd_addr_q <= idx_q;
                        rd_last_q <= idx_last;
                        if (idx_last) begin
                            state_q <= StDrain;
                        end else begin
                            idx_q <= idx_next;
                        end
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (abort) begin
                state_q   <= StIdle;
                rd_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_round_q[i] <= '0;
                fifo_last_q[i]  <= 1'b0;
            end
        end else if (abort) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            if (rd_pend_q) begin
                fifo_data_q[wptr_q]  <= {bank0_q[rd_addr_q], bank1_q[rd_addr_q]};
                fifo_round_q[wptr_q] <= rd_addr_q;
                fifo_last_q[wptr_q]  <= rd_last_q;
                wptr_q               <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
        end
    end

    // key_ready passes a sync stage before the edge detector, hence two edges to key_loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kr_s_q       <= 1'b0;
            kr_q         <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            kr_s_q <= key_ready;
            kr_q   <= kr_s_q;
            if (key_start) begin
                key_loaded_q <= 1'b0;
            end else if (kr_s_q && !kr_q) begin
                key_loaded_q <= 1'b1;
            end
        end
    end

    assign rk_valid   = (cnt_q != 2'd0);
    assign rk_data    = fifo_data_q[rptr_q];
    assign rk_round   = fifo_round_q[rptr_q];
    assign rk_last    = fifo_last_q[rptr_q];
    assign busy       = (state_q != StIdle);
    assign key_loaded = key_loaded_q;
    assign rk_err     = rk_err_q;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store; honours ROUND_KEY_STORE_DEC_EN when choosing expected order.
module tb_round_key_store;

    logic         clk;
    logic         reset;
    logic [1:0]   key_mode;
    logic         key_start;
    logic         key_ready;
    logic         wr;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         rk_start;
    logic         rk_dec;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
    logic         key_loaded;
    logic         rk_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] fips [0:10];
    logic [127:0] exp_key [0:14];

    round_key_store dut (
        .clk        (clk),
        .reset      (reset),
        .key_mode   (key_mode),
        .key_start  (key_start),
        .key_ready  (key_ready),
        .wr         (wr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rk_start   (rk_start),
        .rk_dec     (rk_dec),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
        .rk_last    (rk_last),
        .busy       (busy),
        .key_loaded (key_loaded),
        .rk_err     (rk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int a, input logic [7:0] s);
        logic [31:0] c;
        c = {s, 19'd0, 5'(a)};
        return {c, ~c};
    endfunction

    task automatic write_word(input int a, input logic [63:0] d);
        wr      = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        @(negedge clk);
        wr      = 1'b0;
    endtask

    task automatic pulse_key_ready();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        @(negedge clk);
    endtask

    // Starts a sequence at the current negedge and consumes it, checking order, data and timing.
    task automatic run_seq(input logic [1:0] mode, input bit dec, input int ready_mode,
                           input bit busy_start, input int abort_after, input bit exp_rev,
                           input string tag);
        int nr, cycles, got, first, last_hs, errs, r;
        bit stalled;
        logic [127:0] hd;
        logic [3:0] hr;
        nr = (mode == 2'd0) ? 10 : (mode == 2'd1) ? 12 : 14;
        cycles = 1; got = 0; first = -1; last_hs = -1; errs = 0; stalled = 1'b0;
        hd = '0; hr = '0;
        key_mode = mode;
        rk_dec   = dec;
        rk_start = 1'b1;
        @(negedge clk);
        rk_start = 1'b0;
        check({tag, " busy_rise"}, busy, 1);
        while (got <= nr && cycles < 200) begin
            if (abort_after >= 0 && got == abort_after) begin
                key_start = 1'b1;
                @(negedge clk);
                key_start = 1'b0;
                check({tag, " abort_valid"}, rk_valid, 0);
                check({tag, " abort_busy"}, busy, 0);
                check({tag, " abort_loaded"}, key_loaded, 0);
                return;
            end
            rk_start = busy_start && (cycles == 5);
            rk_ready = (ready_mode == 0) ? 1'b1 : cycles[0];
            if (rk_err) errs++;
            if (stalled) begin
                check({tag, " stall_valid"}, rk_valid, 1);
                check({tag, " stall_data"}, rk_data, hd);
                check({tag, " stall_round"}, rk_round, hr);
            end
            if (rk_valid) begin
                if (first < 0) first = cycles;
                if (rk_ready) begin
                    r = exp_rev ? nr - got : got;
                    check($sformatf("%s round[%0d]", tag, got), rk_round, r);
                    check($sformatf("%s data[%0d]", tag, got), rk_data, exp_key[r]);
                    check($sformatf("%s last[%0d]", tag, got), rk_last, got == nr);
                    got++;
                    last_hs = cycles;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = rk_data;
                    hr = rk_round;
                end
            end
            @(negedge clk);
            cycles++;
        end
        rk_start = 1'b0;
        rk_ready = 1'b0;
        check({tag, " key_count"}, got, nr + 1);
        check({tag, " latency"}, first, 3);
        if (ready_mode == 0) check({tag, " last_cycle"}, last_hs, 3 + nr);
        check({tag, " busy_fall"}, busy, 0);
        check({tag, " valid_end"}, rk_valid, 0);
        check({tag, " no_err"}, errs, 0);
    endtask

    initial begin
        int vcnt;
        bit rev;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef ROUND_KEY_STORE_DEC_EN
        rev = 1'b1;
`else
        rev = 1'b0;
`endif
        reset = 1'b1; key_mode = 2'd0; key_start = 1'b0; key_ready = 1'b0;
        wr = 1'b0; wr_addr = '0; wr_data = '0; rk_start = 1'b0; rk_dec = 1'b0; rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", rk_valid, 0);
        check("rst_data", rk_data, 0);
        check("rst_round", rk_round, 0);
        check("rst_last", rk_last, 0);
        check("rst_busy", busy, 0);
        check("rst_loaded", key_loaded, 0);
        check("rst_err", rk_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Request before any key is loaded.
        rk_start = 1'b1;
        @(negedge clk);
        rk_start = 1'b0;
        check("noload_err", rk_err, 1);
        check("noload_busy", busy, 0);
        @(negedge clk);
        check("noload_err_pulse", rk_err, 0);
        vcnt = 0;
        repeat (4) begin
            if (rk_valid) vcnt++;
            @(negedge clk);
        end
        check("noload_valid", vcnt, 0);

        // AES-128 FIPS-197 key schedule.
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        for (int r = 0; r < 11; r++) begin
            write_word(2 * r, fips[r][127:64]);
            write_word(2 * r + 1, fips[r][63:0]);
        end
        key_ready = 1'b1;
        @(negedge clk);
        check("loaded_edge1", key_loaded, 0);
        key_ready = 1'b0;
        @(negedge clk);
        check("loaded_edge2", key_loaded, 1);
        for (int r = 0; r < 11; r++) exp_key[r] = fips[r];
        run_seq(2'd0, 1'b0, 0, 1'b0, -1, 1'b0, "aes128");

        // Patterned 32-word load, including the never-read addresses 30..31.
        for (int a = 0; a < 32; a++) write_word(a, pat(a, 8'h3c));
        for (int r = 0; r < 15; r++) exp_key[r] = {pat(2 * r, 8'h3c), pat(2 * r + 1, 8'h3c)};
        run_seq(2'd3, 1'b1, 0, 1'b1, -1, rev, "aes256");
        run_seq(2'd1, 1'b0, 1, 1'b0, -1, 1'b0, "aes192");

        // Abort after four keys, then a request must be rejected.
        run_seq(2'd0, 1'b0, 0, 1'b0, 4, 1'b0, "abort");
        rk_start = 1'b1;
        @(negedge clk);
        rk_start = 1'b0;
        check("abort_restart_err", rk_err, 1);
        check("abort_restart_busy", busy, 0);

        // Asynchronous reset mid-sequence.
        pulse_key_ready();
        check("reload", key_loaded, 1);
        key_mode = 2'd0; rk_dec = 1'b0; rk_ready = 1'b1; rk_start = 1'b1;
        @(negedge clk);
        rk_start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_valid", rk_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("areset_valid", rk_valid, 0);
        check("areset_data", rk_data, 0);
        check("areset_round", rk_round, 0);
        check("areset_last", rk_last, 0);
        check("areset_busy", busy, 0);
        check("areset_loaded", key_loaded, 0);
        @(negedge clk);
        reset = 1'b0;
        rk_ready = 1'b0;
        @(negedge clk);
        rk_start = 1'b1;
        @(negedge clk);
        rk_start = 1'b0;
        check("post_reset_err", rk_err, 1);
        pulse_key_ready();
        run_seq(2'd0, 1'b0, 0, 1'b0, -1, 1'b0, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

Round-key storage and sequencer downstream of the key-expansion block. Captures the 64-bit expanded-key write stream (`wr`/`wr_addr`/`wr_data`) into two 16x64 banks and tracks key validity from `key_start`/`key_ready`. On request it streams 128-bit round keys to the cipher datapath over a valid/ready handshake, in forward order for encryption and, optionally, reverse order for decryption.

## Interface
- No parameters; depths fixed: 2 banks x 16 entries x 64 bits.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `key_mode` in 2 — 0: AES-128 (Nr=10), 1: AES-192 (Nr=12), 2: AES-256 (Nr=14); 3 is treated as 2.
- `key_start` in 1 — expansion restart pulse; invalidates the stored key.
- `key_ready` in 1 — expansion complete (level).
- `wr` in 1 — write strobe from key expansion.
- `wr_addr` in 5 — 64-bit word address; bit 0 selects the bank, bits 4:1 the entry.
- `wr_data` in 64 — expanded-key half-word; even address = key bits 127:64.
- `rk_start` in 1 — request a round-key sequence (pulse).
- `rk_dec` in 1 — sampled with `rk_start`; 1 = reverse order.
- `rk_valid` out 1 — round key available.
- `rk_ready` in 1 — consumer accepts the key.
- `rk_data` out 128 — round key {bank0[r], bank1[r]}.
- `rk_round` out 4 — index r of the presented key.
- `rk_last` out 1 — presented key is the final key of the sequence.
- `busy` out 1 — sequence in progress.
- `key_loaded` out 1 — stored key is valid.
- `rk_err` out 1 — one-cycle pulse when `rk_start` is rejected.

## Operation
- Writes: when `wr`=1, `wr_data` is written to bank[`wr_addr[0]`][`wr_addr[4:1]`]. Writes are accepted in every state. Addresses 30–31 are written but never read.
- `key_loaded`: cleared by `key_start`. Set on the `key_ready` 0→1 edge (edge detected using a registered copy). `key_start` and the edge in the same cycle: the clear wins.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `rk_start` && `key_loaded`. This latches `rk_dec` and Nr, and sets the issue index to 0 (forward) or Nr (reverse).
  - `rk_start` with `key_loaded`=0 pulses `rk_err` for one cycle and the FSM stays in IDLE.
  - In RUN, one read of both banks is issued per cycle when credits allow. Credits = 2-entry output FIFO free slots minus reads in flight.
  - After the read of the final index (Nr forward, 0 reverse) is issued, RUN → DRAIN.
  - DRAIN → IDLE when the FIFO is empty and no read is in flight.
- `rk_start` while in RUN or DRAIN is ignored; `rk_err` stays 0.
- Abort: `key_start` in RUN or DRAIN flushes the FIFO, discards the in-flight read, and returns the FSM to IDLE next cycle; `rk_valid`=0 from that cycle.
- Output: `rk_data`/`rk_round`/`rk_last` come from the FIFO head. A key transfers on `rk_valid` && `rk_ready`. Nr+1 keys are sent per sequence, and `rk_last` is set only on the final one.
- Once asserted, `rk_valid` is held with stable data until the key is accepted.
- `busy`=1 in RUN and DRAIN.

## Timing
- Reset values: `rk_valid`=0, `rk_data`=0, `rk_round`=0, `rk_last`=0, `busy`=0, `key_loaded`=0, `rk_err`=0; FSM in IDLE; FIFO empty. Bank contents are undefined.
- `rk_start` sampled at edge T:
  - `busy`=1 after T.
  - Read of the first index issued in the cycle after T; bank output registered at T+2.
  - `rk_valid`=1 after T+2, i.e. 3 cycles of latency.
- With `rk_ready` held at 1: one key per cycle, with no bubbles. The full sequence occupies cycles T+3 … T+3+Nr. `busy` falls at the edge after the last handshake.
- Backpressure: the FIFO never overflows under any `rk_ready` pattern. Throughput recovers to one key per cycle within 1 cycle of `rk_ready` returning high.
- `rk_err` is asserted in the cycle after T.
- `key_loaded` rises 2 edges after `key_ready` rises and falls 1 edge after `key_start`.

## Configuration
- `ROUND_KEY_STORE_DEC_EN` defined: `rk_dec` is honoured (reverse order Nr…0 when `rk_dec`=1).
- `ROUND_KEY_STORE_DEC_EN` undefined: `rk_dec` is ignored and every sequence runs forward 0…Nr. The down-count logic is not built.

## Test plan
- AES-128 FIPS-197 key 2b7e1516…09cf4f3c: load 22 words, pulse `key_ready`, then `rk_start` with `rk_ready`=1 → 11 keys on consecutive cycles. Key 0 = 2b7e1516…, key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last`=1; first `rk_valid` 3 cycles after `rk_start`.
- AES-256 with `rk_dec`=1 (macro defined) → 15 keys, `rk_round` 14…0, `rk_last` on round 0. With the macro undefined, the same stimulus gives order 0…14.
- AES-192, `rk_ready` toggling every cycle → 13 keys, none lost or duplicated, data stable while stalled, `busy` falls after the 13th handshake.
- `rk_start` before `key_ready` → `rk_err` one cycle, no `rk_valid`. Second `rk_start` while busy → ignored, sequence unaffected.
- `key_start` mid-sequence after 4 keys → `rk_valid`=0 next cycle, `busy`=0, `key_loaded`=0. A following `rk_start` → `rk_err`.
- `reset` asserted mid-sequence → all outputs return to reset values asynchronously. The next sequence requires a fresh `key_ready` edge.
